// File: rtl/mxint_circular_sched.sv
// mxint_circular_sched
//   Replay scheduler for MXINT block streams. It captures a group of
//   BUFFER_SIZE MX blocks (IN_NUM mantissas plus one shared exponent each)
//   into register storage. It then replays the group in order REPEAT times
//   on a registered valid/ready output. After that it returns to capture the
//   next group.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   mdata_in        IN_NUM x DATA_PRECISION_0 mantissas (element 0 in LSBs)
//   edata_in        shared exponent
//   data_in_valid   input block valid
//   data_in_ready   high in FILL
//   mdata_out       registered output mantissas
//   edata_out       registered output exponent
//   data_out_valid  registered output valid
//   data_out_ready  consumer accepts block
//   busy            high while in REPLAY
//   pass_idx        replay pass currently being issued
//
// state  | meaning
// FILL   | accepting input blocks into storage; drains a pending output block
// REPLAY | issuing storage[rd_ptr] into the output register, REPEAT passes
module mxint_circular_sched #(
  parameter int DATA_PRECISION_0 = 16,
  parameter int DATA_PRECISION_1 = 8,
  parameter int IN_NUM           = 1,
  parameter int REPEAT           = 8,
  parameter int BUFFER_SIZE      = 4,
  localparam int MW = IN_NUM * DATA_PRECISION_0,
  localparam int AW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1,
  localparam int PW = (REPEAT > 1) ? $clog2(REPEAT) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [MW-1:0]               mdata_in,
  input  logic [DATA_PRECISION_1-1:0] edata_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic [MW-1:0]               mdata_out,
  output logic [DATA_PRECISION_1-1:0] edata_out,
  output logic                        data_out_valid,
  input  logic                        data_out_ready,
  output logic                        busy,
  output logic [PW-1:0]               pass_idx
);

  localparam int DW = MW + DATA_PRECISION_1;

  typedef enum logic {FILL, REPLAY} state_t;

  state_t                      state_q, state_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]               pass_q, pass_d;
  logic                        vld_q, vld_d;
  logic [MW-1:0]               mant_q, mant_d;
  logic [DATA_PRECISION_1-1:0] exp_q, exp_d;
  logic [DW-1:0]               mem_q [BUFFER_SIZE];
  logic                        wr_en;
  logic                        load;

  // The output register may be refilled when it is empty or when its
  // current block is being taken this cycle.
  assign load = !vld_q || data_out_ready;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pass_d        = pass_q;
    vld_d         = vld_q;
    mant_d        = mant_q;
    exp_d         = exp_q;
    wr_en         = 1'b0;
    data_in_ready = 1'b0;
    case (state_q)
      FILL: begin
        data_in_ready = 1'b1;
        // The last replayed block of the previous group may still be
        // pending here; storage reads are done so overwriting is safe.
        if (vld_q && data_out_ready) vld_d = 1'b0;
        if (data_in_valid) begin
          wr_en = 1'b1;
          if (wr_ptr_q == AW'(BUFFER_SIZE - 1)) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pass_d   = '0;
            state_d  = REPLAY;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
      end
      REPLAY: begin
        if (load) begin
          {mant_d, exp_d} = mem_q[rd_ptr_q];
          vld_d           = 1'b1;
          if (rd_ptr_q == AW'(BUFFER_SIZE - 1)) begin
            rd_ptr_d = '0;
            if (pass_q == PW'(REPEAT - 1)) begin
              // pass_idx is left at its final value until the next group.
              state_d  = FILL;
              wr_ptr_d = '0;
            end else begin
              pass_d = pass_q + PW'(1);
            end
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pass_q   <= '0;
      vld_q    <= 1'b0;
      mant_q   <= '0;
      exp_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pass_q   <= pass_d;
      vld_q    <= vld_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
    end
  end

  // Storage needs no reset; its contents are only read after a full fill.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {mdata_in, edata_in};
  end

  assign mdata_out      = mant_q;
  assign edata_out      = exp_q;
  assign data_out_valid = vld_q;
  assign busy           = (state_q == REPLAY);
  assign pass_idx       = pass_q;

endmodule

// File: tb/tb_mxint_circular_sched.sv
module tb_mxint_circular_sched;

  localparam int B0 = 4, R0 = 3, B1 = 1, R1 = 1;

  typedef struct packed {logic [15:0] m; logic [7:0] e;} blk_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] m_in [2];
  logic [7:0]  e_in [2];
  logic        v_in [2];
  logic        din_r [2];
  logic [15:0] m_out [2];
  logic [7:0]  e_out [2];
  logic        v_out [2];
  logic        r_out [2];
  logic        busy [2];
  logic [1:0]  pidx0;
  logic [0:0]  pidx1;

  always #5 clk = ~clk;

  mxint_circular_sched #(.DATA_PRECISION_0(16), .DATA_PRECISION_1(8), .IN_NUM(1),
                         .REPEAT(R0), .BUFFER_SIZE(B0)) u_a (
    .clk(clk), .rst(rst), .mdata_in(m_in[0]), .edata_in(e_in[0]),
    .data_in_valid(v_in[0]), .data_in_ready(din_r[0]),
    .mdata_out(m_out[0]), .edata_out(e_out[0]), .data_out_valid(v_out[0]),
    .data_out_ready(r_out[0]), .busy(busy[0]), .pass_idx(pidx0));

  mxint_circular_sched #(.DATA_PRECISION_0(16), .DATA_PRECISION_1(8), .IN_NUM(1),
                         .REPEAT(R1), .BUFFER_SIZE(B1)) u_b (
    .clk(clk), .rst(rst), .mdata_in(m_in[1]), .edata_in(e_in[1]),
    .data_in_valid(v_in[1]), .data_in_ready(din_r[1]),
    .mdata_out(m_out[1]), .edata_out(e_out[1]), .data_out_valid(v_out[1]),
    .data_out_ready(r_out[1]), .busy(busy[1]), .pass_idx(pidx1));

  // Model: expected output blocks in issue order, plus transfer bookkeeping.
  blk_t q0[$];
  blk_t q1[$];
  blk_t grp [2][4];
  int   gcnt [2];
  int   pushed [2];
  int   txn [2];
  int   base [2];
  int   vrun [2];
  int   vmax [2];
  int   vcyc [2];
  int   n99;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic int bsize(input int d); return (d == 0) ? B0 : B1; endfunction
  function automatic int rpt(input int d);   return (d == 0) ? R0 : R1; endfunction
  function automatic int qsize(input int d); return (d == 0) ? q0.size() : q1.size(); endfunction
  function automatic blk_t qfront(input int d); return (d == 0) ? q0[0] : q1[0]; endfunction
  function automatic int pval(input int d);  return (d == 0) ? int'(pidx0) : int'(pidx1); endfunction

  task automatic qpop(input int d);
    if (d == 0) q0.delete(0); else q1.delete(0);
  endtask

  task automatic qpush(input int d, input blk_t b);
    if (d == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      gcnt[d] = 0; pushed[d] = 0; txn[d] = 0; base[d] = 0;
      vrun[d] = 0; vmax[d] = 0; vcyc[d] = 0;
    end
    n99 = 0;
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      for (int d = 0; d < 2; d++) begin
        gcnt[d] = 0; pushed[d] = 0; txn[d] = 0; base[d] = 0; vrun[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int   pend;
        int   lg;
        int   ep;
        blk_t f;
        // Blocks of the captured groups not yet loaded into the output reg.
        pend = pushed[d] - txn[d] - (v_out[d] ? 1 : 0);
        chk($sformatf("in_ready[%0d]", d), int'(din_r[d]), int'(pend == 0));
        chk($sformatf("busy[%0d]", d), int'(busy[d]), int'(pend != 0));
        lg = txn[d] + (v_out[d] ? 1 : 0) - base[d];
        ep = lg / bsize(d);
        if (ep > rpt(d) - 1) ep = rpt(d) - 1;
        chk($sformatf("pass_idx[%0d]", d), pval(d), ep);
        if (v_out[d]) begin
          vrun[d]++;
          vcyc[d]++;
          if (vrun[d] > vmax[d]) vmax[d] = vrun[d];
          chk($sformatf("out_expected[%0d]", d), int'(qsize(d) > 0), 1);
          if (qsize(d) > 0) begin
            f = qfront(d);
            chk($sformatf("mdata_out[%0d]", d), int'(m_out[d]), int'(f.m));
            chk($sformatf("edata_out[%0d]", d), int'(e_out[d]), int'(f.e));
            if (r_out[d]) begin
              qpop(d);
              txn[d]++;
              if (d == 0 && f.m == 16'd99) n99++;
            end
          end
        end else begin
          vrun[d] = 0;
        end
        if (v_in[d] && din_r[d]) begin
          grp[d][gcnt[d]] = '{m: m_in[d], e: e_in[d]};
          gcnt[d]++;
          if (gcnt[d] == bsize(d)) begin
            base[d] = pushed[d];
            for (int p = 0; p < rpt(d); p++)
              for (int j = 0; j < bsize(d); j++) qpush(d, grp[d][j]);
            pushed[d] += bsize(d) * rpt(d);
            gcnt[d] = 0;
          end
        end
      end
    end
  end

  // Callers are always at posedge+1 when this starts.
  task automatic send(input int d, input logic [15:0] m, input logic [7:0] e);
    int ok = 0;
    m_in[d] = m; e_in[d] = e; v_in[d] = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (din_r[d]) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    v_in[d] = 1'b0;
    if (ok == 0) chk("send_accept", ok, 1);
  endtask

  task automatic drain(input int d, input string nm);
    int ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (qsize(d) == 0 && !v_out[d] && gcnt[d] == 0) begin ok = 1; break; end
    end
    chk(nm, ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int pmax;
    int ok;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_in[d] = '0; e_in[d] = '0; v_in[d] = 1'b0; r_out[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(v_out[0]), 0);
    chk("rst_mdata", int'(m_out[0]), 0);
    chk("rst_edata", int'(e_out[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_in_ready", int'(din_r[0]), 1);
    chk("rst_pass", int'(pidx0), 0);
    rst = 1'b0;

    // Test 1: ready held high, latency and no bubbles.
    for (int k = 0; k < 4; k++) send(0, 16'(10 * (k + 1)), 8'(k + 1));
    chk("t1_not_yet_valid", int'(v_out[0]), 0);
    @(posedge clk); #1;
    chk("t1_first_valid", int'(v_out[0]), 1);
    chk("t1_first_m", int'(m_out[0]), 10);
    chk("t1_first_e", int'(e_out[0]), 1);
    for (int i = 1; i < 12; i++) begin
      @(posedge clk); #1;
      chk("t1_no_bubble", int'(v_out[0]), 1);
    end
    @(posedge clk); #1;
    chk("t1_done_valid", int'(v_out[0]), 0);
    chk("t1_transfers", txn[0], 12);

    // Test 2: random consumer stalls.
    t0 = txn[0];
    for (int k = 0; k < 4; k++) send(0, 16'h1001 + 16'(k), 8'h40 + 8'(k));
    pmax = 0;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (int'(pidx0) > pmax) pmax = int'(pidx0);
      if (qsize(0) == 0 && !v_out[0]) begin ok = 1; break; end
      r_out[0] = 1'($urandom_range(0, 1));
    end
    r_out[0] = 1'b1;
    chk("t2_drained", ok, 1);
    chk("t2_transfers", txn[0] - t0, 12);
    chk("t2_pass_max", pmax, 2);

    // Test 4: input 99 offered throughout REPLAY.
    t0 = txn[0];
    for (int k = 0; k < 4; k++) send(0, 16'(k + 1), 8'h21 + 8'(k));
    send(0, 16'd99, 8'h63);
    chk("t4_99_after_replay", txn[0] - t0, 12);
    send(0, 16'd100, 8'h64);
    send(0, 16'd101, 8'h65);
    send(0, 16'd102, 8'h66);
    drain(0, "t4_drain");
    chk("t4_99_count", n99, 3);

    // Test 5: last replayed block held while the next group fills.
    t0 = txn[0];
    for (int k = 0; k < 4; k++) send(0, 16'h50 + 16'(k), 8'h10 + 8'(k));
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (txn[0] - t0 == 11) begin r_out[0] = 1'b0; break; end
    end
    chk("t5_reach_last", txn[0] - t0, 11);
    for (int k = 0; k < 4; k++) send(0, 16'hA + 16'(k), 8'hA + 8'(k));
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_held_valid", int'(v_out[0]), 1);
    chk("t5_held_m", int'(m_out[0]), 'h53);
    chk("t5_busy", int'(busy[0]), 1);
    r_out[0] = 1'b1;
    @(posedge clk); #1;
    chk("t5_first_A_valid", int'(v_out[0]), 1);
    chk("t5_first_A", int'(m_out[0]), 'hA);
    drain(0, "t5_drain");

    // Test 3: B=1, R=1 pipeline behaviour.
    for (int k = 0; k < 5; k++) begin
      send(1, 16'(7 + k), 8'(k));
      chk("t3_in_ready_low", int'(din_r[1]), 0);
      chk("t3_busy", int'(busy[1]), 1);
    end
    drain(1, "t3_drain");
    chk("t3_valid_cycles", vcyc[1], 5);
    chk("t3_bubble", vmax[1], 1);

    // Test 6: reset in the middle of pass 1.
    for (int k = 0; k < 4; k++) send(0, 16'h60 + 16'(k), 8'h30 + 8'(k));
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (pidx0 == 2'd1) begin ok = 1; break; end
    end
    chk("t6_reach_pass1", ok, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", int'(v_out[0]), 0);
    chk("t6_rst_busy", int'(busy[0]), 0);
    chk("t6_rst_in_ready", int'(din_r[0]), 1);
    chk("t6_rst_pass", int'(pidx0), 0);
    chk("t6_rst_m", int'(m_out[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) send(0, 16'h70 + 16'(k), 8'h70 + 8'(k));
    @(posedge clk); #1;
    chk("t6_first_valid", int'(v_out[0]), 1);
    chk("t6_first_m", int'(m_out[0]), 'h70);
    chk("t6_first_pass", int'(pidx0), 0);
    drain(0, "t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
